// File: rtl/rf_wb_queue.sv
// Writeback queue in front of a single-write-port register file, with hazard lookup for two read ports.
// Optional same-cycle bypass when empty: define RF_WB_BYPASS_EN.
module rf_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 4,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_valid,
   input  logic [AW-1:0]            wb_addr,
   input  logic [DW-1:0]            wb_data,
   output logic                     wb_ready,
   input  logic                     drain_en,
   output logic                     wea,
   output logic [AW-1:0]            waddr,
   output logic [DW-1:0]            wdata,
   input  logic [AW-1:0]            q0addr,
   input  logic [AW-1:0]            q1addr,
   output logic                     q0pend,
   output logic                     q1pend,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [AW-1:0] addr_d [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [DW-1:0] data_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wea_q, wea_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          push_s, pop_s, bypass_s;
   logic          q0_hit_s, q1_hit_s;

   // Entry idx holds live data when its distance from the head is below the fill level.
   function automatic logic occupied(input logic [PW-1:0] idx, input logic [PW-1:0] rd,
                                     input logic [CW-1:0] cnt);
      logic [PW-1:0] off;
      off = idx - rd;
      return ({1'b0, off} < cnt);
   endfunction

   // Handshake decode: accept, drain and (optionally) bypass conditions.
   always_comb begin
      wb_ready = (count_q < CW'(DEPTH));
      pop_s    = drain_en && (count_q != '0);
`ifdef RF_WB_BYPASS_EN
      bypass_s = drain_en && wb_valid && (count_q == '0);
`else
      bypass_s = 1'b0;
`endif
      push_s   = wb_valid && wb_ready && !bypass_s;
   end

   // Next-state for storage, pointers, fill level and the registered write port.
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      wea_d    = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      count_d  = count_q;

      if (push_s) begin
         addr_d[wr_ptr_q] = wb_addr;
         data_d[wr_ptr_q] = wb_data;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         wea_d    = 1'b1;
         waddr_d  = addr_q[rd_ptr_q];
         wdata_d  = data_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else if (bypass_s) begin
         wea_d   = 1'b1;
         waddr_d = wb_addr;
         wdata_d = wb_data;
      end else begin
         wea_d = 1'b0;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Hazard lookup: any live entry or the write currently on the port.
   always_comb begin
      q0_hit_s = wea_q && (waddr_q == q0addr);
      q1_hit_s = wea_q && (waddr_q == q1addr);
      for (int i = 0; i < DEPTH; i++) begin
         if (occupied(PW'(i), rd_ptr_q, count_q)) begin
            if (addr_q[i] == q0addr) q0_hit_s = 1'b1;
            else                     q0_hit_s = q0_hit_s;
            if (addr_q[i] == q1addr) q1_hit_s = 1'b1;
            else                     q1_hit_s = q1_hit_s;
         end else begin
            q0_hit_s = q0_hit_s;
            q1_hit_s = q1_hit_s;
         end
      end
      q0pend = q0_hit_s;
      q1pend = q1_hit_s;
   end

   // State registers; reset discards queued entries and clears the write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= '{default: '0};
         data_q   <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         wea_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         wea_q    <= wea_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign wea   = wea_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;
   assign count = count_q;

endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: stimulus queues expected writes, a negedge monitor checks the write port.
module tb_rf_wb_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 4;
   localparam int DW    = 32;
`ifdef RF_WB_BYPASS_EN
   localparam int LAT_EXTRA = 0;
`else
   localparam int LAT_EXTRA = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          wb_ready;
   logic          drain_en;
   logic          wea;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] q0addr, q1addr;
   logic          q0pend, q1pend;
   logic [2:0]    count;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            edge_n;
      bit            chk_lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;

   rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_ready(wb_ready), .drain_en(drain_en), .wea(wea), .waddr(waddr), .wdata(wdata),
      .q0addr(q0addr), .q1addr(q1addr), .q0pend(q0pend), .q1pend(q1pend), .count(count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every write-port pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (wea === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 64'(waddr), 64'hDEAD);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("waddr", 64'(waddr), 64'(e.addr));
            check("wdata", 64'(wdata), 64'(e.data));
            if (e.chk_lat) check("latency_edge", 64'(edge_cnt), 64'(e.edge_n + LAT_EXTRA));
         end
      end
   end

   // Present one request for one cycle; exp_acc is the bench's own prediction of wb_ready.
   task automatic drive_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit exp_acc, input bit record, input bit chk_lat);
      exp_t e;
      wb_valid = 1'b1;
      wb_addr  = a;
      wb_data  = d;
      #1;
      check("wb_ready_at_req", 64'(wb_ready), 64'(exp_acc));
      if (exp_acc && record) begin
         e.addr = a; e.data = d; e.edge_n = edge_cnt + 1; e.chk_lat = chk_lat;
         sb.push_back(e);
      end
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=%0d required=%0d", edge_cnt, 0);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      drain_en = 1'b0; q0addr = '0; q1addr = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_wea", 64'(wea), 64'd0);
      check("rst_waddr", 64'(waddr), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_ready", 64'(wb_ready), 64'd1);
      check("rst_q0pend", 64'(q0pend), 64'd0);
      check("rst_q1pend", 64'(q1pend), 64'd0);
      @(negedge clk);
      check("idle_wea", 64'(wea), 64'd0);

      // Fill with the write port blocked, then try one more while full.
      drive_req(4'hC, 32'hFFFFEEEE, 1'b1, 1'b1, 1'b0);
      drive_req(4'h9, 32'h9999EEEE, 1'b1, 1'b1, 1'b0);
      drive_req(4'h4, 32'hABCDABCD, 1'b1, 1'b1, 1'b0);
      drive_req(4'h5, 32'hABCDABCD, 1'b1, 1'b1, 1'b0);
      drive_req(4'h1, 32'h11111111, 1'b0, 1'b1, 1'b0);
      check("full_count", 64'(count), 64'd4);
      check("full_ready", 64'(wb_ready), 64'd0);
      check("full_wea", 64'(wea), 64'd0);
      q0addr = 4'h9; q1addr = 4'h0;
      #1;
      check("full_q0pend", 64'(q0pend), 64'd1);
      check("full_q1pend", 64'(q1pend), 64'd0);
      q1addr = 4'h5;
      #1;
      check("full_q1pend_tail", 64'(q1pend), 64'd1);

      // Drain: four back-to-back write pulses, then idle.
      drain_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("drain_wea", 64'(wea), 64'd1);
      end
      @(negedge clk);
      check("drained_wea", 64'(wea), 64'd0);
      check("drained_count", 64'(count), 64'd0);
      @(negedge clk);
      check("empty_wea", 64'(wea), 64'd0);
      check("empty_ready", 64'(wb_ready), 64'd1);

      // Streaming same-address writes with the port always granted.
      q0addr = 4'h9;
      for (int i = 0; i < 6; i++) begin
         drive_req(4'h9, (i % 2 == 0) ? 32'h88887777 : 32'h12341234, 1'b1, 1'b1, 1'b1);
         #1;
         check("stream_q0pend", 64'(q0pend), 64'd1);
         check("stream_count_le1", 64'(count <= 3'd1), 64'd1);
      end
      repeat (3) @(negedge clk);
      check("stream_done_wea", 64'(wea), 64'd0);
      check("stream_sb_empty", 64'(sb.size()), 64'd0);

      // Queued entries are discarded by reset and never written.
      drain_en = 1'b0;
      drive_req(4'h2, 32'h22222222, 1'b1, 1'b0, 1'b0);
      drive_req(4'h3, 32'h33333333, 1'b1, 1'b0, 1'b0);
      drive_req(4'h6, 32'h66666666, 1'b1, 1'b0, 1'b0);
      check("prerst_count", 64'(count), 64'd3);
      reset = 1'b1;
      #1;
      check("inrst_ready", 64'(wb_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("postrst_count", 64'(count), 64'd0);
      check("postrst_waddr", 64'(waddr), 64'd0);
      check("postrst_wdata", 64'(wdata), 64'd0);
      check("postrst_ready", 64'(wb_ready), 64'd1);
      drain_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("postrst_wea", 64'(wea), 64'd0);
      end
      check("postrst_count_end", 64'(count), 64'd0);
      check("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
